// File: rtl/decode_stage.sv
// ID stage: decodes one RV32I-subset instruction per cycle into an ID/EX register,
// with valid/ready handshake, flush and load-use bubbles. Optional macro: DECODE_ILLEGAL_TRAP_EN.
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       imm,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic                  use_imm,
    output logic [1:0]            mem_ctrl,
    output logic                  reg_we,
    output logic                  is_branch,
    output logic                  illegal
);
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [ALUOP_W-1:0] ALU_NOP   = ALUOP_W'(4'd0);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(4'd1);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(4'd2);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4'd3);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(4'd4);
    localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(4'd5);
    localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(4'd6);
    localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(4'd7);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(4'd8);

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic [6:0]            funct7_s;
    logic [REG_ADDR_W-1:0] rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0]       imm_s;
    logic [ALUOP_W-1:0]    alu_s, dec_alu_s;
    logic [1:0]            mem_s, dec_mem_s;
    logic                  use_imm_s, reg_we_s, branch_s, legal_s;
    logic                  dec_use_imm_s, dec_reg_we_s, dec_branch_s;
    logic                  uses_rs1_s, uses_rs2_s, hz_s, accept_s, trap_s, ill_s;

    assign opcode_s = inst_i[6:0];
    assign funct3_s = inst_i[14:12];
    assign funct7_s = inst_i[31:25];
    assign rs1_s    = REG_ADDR_W'(inst_i[19:15]);
    assign rs2_s    = REG_ADDR_W'(inst_i[24:20]);
    assign rd_s     = REG_ADDR_W'(inst_i[11:7]);

    // Opcode/funct decode into a raw control word and sign-extended immediate
    always_comb begin
        imm_s     = {XLEN{1'b0}};
        alu_s     = ALU_NOP;
        use_imm_s = 1'b0;
        mem_s     = MEM_NOP;
        reg_we_s  = 1'b0;
        branch_s  = 1'b0;
        legal_s   = 1'b0;
        case (opcode_s)
            OPC_OPIMM: begin
                imm_s     = XLEN'($signed(inst_i[31:20]));
                use_imm_s = 1'b1;
                reg_we_s  = 1'b1;
                legal_s   = 1'b1;
                case (funct3_s)
                    3'b000:  alu_s = ALU_ADD;
                    3'b110:  alu_s = ALU_OR;
                    3'b111:  alu_s = ALU_AND;
                    3'b100:  alu_s = ALU_XOR;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                imm_s     = XLEN'($signed(inst_i[31:20]));
                alu_s     = ALU_ADD;
                use_imm_s = 1'b1;
                mem_s     = MEM_READ;
                reg_we_s  = 1'b1;
                legal_s   = (funct3_s == 3'b010);
            end
            OPC_STORE: begin
                imm_s     = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                alu_s     = ALU_ADD;
                use_imm_s = 1'b1;
                mem_s     = MEM_WRITE;
                legal_s   = (funct3_s == 3'b010);
            end
            OPC_OP: begin
                reg_we_s = 1'b1;
                legal_s  = 1'b1;
                case ({funct7_s, funct3_s})
                    {7'b0000000, 3'b000}: alu_s = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_s = ALU_SUB;
                    {7'b0000000, 3'b110}: alu_s = ALU_OR;
                    {7'b0000000, 3'b111}: alu_s = ALU_AND;
                    {7'b0000000, 3'b100}: alu_s = ALU_XOR;
                    default:              legal_s = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                imm_s    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
                branch_s = 1'b1;
                legal_s  = 1'b1;
                case (funct3_s)
                    3'b000:  alu_s = ALU_BEQ;
                    3'b001:  alu_s = ALU_BNE;
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LUI: begin
                imm_s     = XLEN'($signed({inst_i[31:12], 12'b0}));
                alu_s     = ALU_PASSB;
                use_imm_s = 1'b1;
                reg_we_s  = 1'b1;
                legal_s   = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Unsupported encodings collapse to a NOP control word; writes to x0 are suppressed
    assign dec_alu_s     = legal_s ? alu_s : ALU_NOP;
    assign dec_mem_s     = legal_s ? mem_s : MEM_NOP;
    assign dec_use_imm_s = legal_s & use_imm_s;
    assign dec_branch_s  = legal_s & branch_s;
    assign dec_reg_we_s  = legal_s & reg_we_s & (inst_i[11:7] != 5'd0);

    assign uses_rs1_s = (opcode_s != OPC_LUI);
    assign uses_rs2_s = (opcode_s == OPC_OP) | (opcode_s == OPC_STORE) | (opcode_s == OPC_BRANCH);

    assign hz_s = out_valid & (mem_ctrl == MEM_READ) & (rd != {REG_ADDR_W{1'b0}}) & in_valid &
                  ((uses_rs1_s & (rs1_s == rd)) | (uses_rs2_s & (rs2_s == rd)));

    assign in_ready = (~out_valid | out_ready) & ~hz_s & ~flush & ~trap_s;
    assign accept_s = in_valid & in_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic trap_r;

    // Sticky halt after the first accepted illegal entry; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else if (accept_s & ~legal_s) begin
            trap_r <= 1'b1;
        end else begin
            trap_r <= trap_r;
        end
    end

    assign trap_s = trap_r;
    assign ill_s  = ~legal_s;
`else
    assign trap_s = 1'b0;
    assign ill_s  = 1'b0;
`endif

    // ID/EX register: flush kills, accept loads, consume without refill leaves a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= {XLEN{1'b0}};
            rs1       <= {REG_ADDR_W{1'b0}};
            rs2       <= {REG_ADDR_W{1'b0}};
            rd        <= {REG_ADDR_W{1'b0}};
            imm       <= {XLEN{1'b0}};
            alu_op    <= ALU_NOP;
            use_imm   <= 1'b0;
            mem_ctrl  <= MEM_NOP;
            reg_we    <= 1'b0;
            is_branch <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_pc    <= pc_i;
            rs1       <= rs1_s;
            rs2       <= rs2_s;
            rd        <= rd_s;
            imm       <= imm_s;
            alu_op    <= dec_alu_s;
            use_imm   <= dec_use_imm_s;
            mem_ctrl  <= dec_mem_s;
            reg_we    <= dec_reg_we_s;
            is_branch <= dec_branch_s;
            illegal   <= ill_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_decode_stage;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [31:0] ADDI = 32'h00500093, BEQ = 32'hFE000EE3, SW = 32'h0020A423;
    localparam logic [31:0] LW = 32'h0000A103, ADD = 32'h001101B3, LUI = 32'h123452B7;
    localparam logic [31:0] ILL = 32'h0000007F;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, flush, out_ready, out_valid;
    logic [31:0] inst_i, pc_i, out_pc, imm;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] alu_op;
    logic [1:0] mem_ctrl;
    logic use_imm, reg_we, is_branch, illegal;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .pc_i(pc_i), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .alu_op(alu_op), .use_imm(use_imm), .mem_ctrl(mem_ctrl),
        .reg_we(reg_we), .is_branch(is_branch), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        use_imm;
        logic [1:0]  mem;
        logic        we;
        logic        br;
        logic        ill;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
        dec_t        d;
    } ent_t;

    ent_t m;
    dec_t nd;
    bit   m_trap, m_acc, acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Two's-complement value of an n-bit field, folded to 32 bits
    function automatic logic [31:0] sext(input longint val, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        if (val >= half) val = val - 2 * half;
        return 32'(val);
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int f3, f7, opc;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        opc = int'(w[6:0]);
        d = '0;
        if (opc == 'h13 || opc == 'h03) d.imm = sext(longint'(w[31:20]), 12);
        else if (opc == 'h23) d.imm = sext(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
        else if (opc == 'h63) d.imm = sext(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                                           longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
        else if (opc == 'h37) d.imm = 32'(longint'(w[31:12]) * 4096);
        if (opc == 'h13) begin
            if (f3 == 0) d.alu = 4'd1;
            else if (f3 == 6) d.alu = 4'd3;
            else if (f3 == 7) d.alu = 4'd4;
            else if (f3 == 4) d.alu = 4'd5;
            d.use_imm = 1'b1; d.we = 1'b1;
        end else if (opc == 'h03 && f3 == 2) begin
            d.alu = 4'd1; d.use_imm = 1'b1; d.mem = 2'd1; d.we = 1'b1;
        end else if (opc == 'h23 && f3 == 2) begin
            d.alu = 4'd1; d.use_imm = 1'b1; d.mem = 2'd2;
        end else if (opc == 'h33) begin
            if (f7 == 0 && f3 == 0) d.alu = 4'd1;
            else if (f7 == 32 && f3 == 0) d.alu = 4'd2;
            else if (f7 == 0 && f3 == 6) d.alu = 4'd3;
            else if (f7 == 0 && f3 == 7) d.alu = 4'd4;
            else if (f7 == 0 && f3 == 4) d.alu = 4'd5;
            d.we = 1'b1;
        end else if (opc == 'h63) begin
            if (f3 == 0) d.alu = 4'd6;
            else if (f3 == 1) d.alu = 4'd7;
            d.br = 1'b1;
        end else if (opc == 'h37) begin
            d.alu = 4'd8; d.use_imm = 1'b1; d.we = 1'b1;
        end
        d.ill = (d.alu == 4'd0);
        if (d.ill) begin d.use_imm = 1'b0; d.mem = 2'd0; d.we = 1'b0; d.br = 1'b0; end
        if (w[11:7] == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    function automatic bit exp_ready();
        bit r1, r2, hz;
        r1 = (inst_i[6:0] != 7'h37);
        r2 = (inst_i[6:0] inside {7'h33, 7'h23, 7'h63});
        hz = m.v && m.d.mem == 2'd1 && m.rd != 5'd0 && in_valid &&
             ((r1 && inst_i[19:15] == m.rd) || (r2 && inst_i[24:20] == m.rd));
        return (!m.v || out_ready) && !hz && !flush && !m_trap;
    endfunction

    // Reference pipeline register
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '0; m_trap = 1'b0; m_acc = 1'b0;
        end else begin
            nd = ref_decode(inst_i);
            acc = in_valid && exp_ready();
            m_acc = acc;
            if (flush) m.v = 1'b0;
            else if (acc) begin
                m.v = 1'b1; m.pc = pc_i; m.d = nd;
                m.rs1 = inst_i[19:15]; m.rs2 = inst_i[24:20]; m.rd = inst_i[11:7];
                m.ill = TRAP && nd.ill;
                if (TRAP && nd.ill) m_trap = 1'b1;
            end else if (out_ready) m.v = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, m.v);
            chk("in_ready", in_ready, exp_ready());
            chk("out_pc", out_pc, m.pc);
            chk("rs1", rs1, m.rs1);
            chk("rs2", rs2, m.rs2);
            chk("rd", rd, m.rd);
            chk("imm", imm, m.d.imm);
            chk("alu_op", alu_op, m.d.alu);
            chk("use_imm", use_imm, m.d.use_imm);
            chk("mem_ctrl", mem_ctrl, m.d.mem);
            chk("reg_we", reg_we, m.d.we);
            chk("is_branch", is_branch, m.d.br);
            chk("illegal", illegal, m.ill);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc);
        step(); in_valid = 1'b1; inst_i = w; pc_i = pc;
        step(); in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0] opc;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: opc = 7'h13;  1: opc = 7'h03;  2: opc = 7'h23;  3: opc = 7'h33;
            4: opc = 7'h63;  5: opc = 7'h37;  6: opc = 7'($urandom);
            default: opc = 7'h03;
        endcase
        w[6:0] = opc;
        if ($urandom_range(0, 3) != 0) begin
            if (opc == 7'h03 || opc == 7'h23) w[14:12] = 3'b010;
            else if (opc == 7'h63) w[14:12] = 3'($urandom_range(0, 1));
            else w[14:12] = 3'b000;
            w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        end
        w[11:7] = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    logic [31:0] cur;

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; inst_i = '0; pc_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0); chk("rst_imm", imm, 0); chk("rst_alu_op", alu_op, 0);

        offer(ADDI, 32'h100);
        @(negedge clk);
        chk("addi_valid", out_valid, 1); chk("addi_alu", alu_op, 1); chk("addi_imm", imm, 5);
        chk("addi_rd", rd, 1); chk("addi_use_imm", use_imm, 1); chk("addi_we", reg_we, 1);

        offer(BEQ, 32'h104);
        @(negedge clk);
        chk("beq_imm", imm, 32'hFFFFFFFC); chk("beq_alu", alu_op, 6);
        chk("beq_branch", is_branch, 1); chk("beq_we", reg_we, 0);

        offer(SW, 32'h108);
        @(negedge clk);
        chk("sw_imm", imm, 8); chk("sw_mem", mem_ctrl, 2);

        step(); in_valid = 1'b1; inst_i = LW; pc_i = 32'h10C;
        step(); inst_i = ADD; pc_i = 32'h110;
        @(negedge clk); chk("lu_hz_ready", in_ready, 0);
        step();
        @(negedge clk); chk("lu_bubble", out_valid, 0); chk("lu_ready_after", in_ready, 1);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("lu_add_valid", out_valid, 1); chk("lu_add_alu", alu_op, 1);
        chk("lu_add_we", reg_we, 1); chk("lu_add_rd", rd, 3);

        step(); in_valid = 1'b1; inst_i = ADDI; pc_i = 32'h114;
        step(); out_ready = 1'b0; inst_i = SW; pc_i = 32'h118;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", in_ready, 0); chk("bp_imm", imm, 5); chk("bp_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        step(); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); chk("bp_next_imm", imm, 8); chk("bp_next_mem", mem_ctrl, 2);

        step(); flush = 1'b1; in_valid = 1'b1; inst_i = LUI; pc_i = 32'h11C;
        step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("flush_valid", out_valid, 0); chk("flush_dropped_imm", imm, 8);

        offer(LUI, 32'h120);
        @(negedge clk);
        chk("lui_imm", imm, 32'h12345000); chk("lui_alu", alu_op, 8); chk("lui_rd", rd, 5);

        step(); in_valid = 1'b1; inst_i = ILL; pc_i = 32'h124;
        step(); inst_i = ADDI; pc_i = 32'h128; out_ready = 1'b0;
        @(negedge clk);
        chk("ill_flag", illegal, TRAP); chk("ill_alu", alu_op, 0);
        chk("ill_valid", out_valid, 1); chk("ill_we", reg_we, 0);
        step(); out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("trap_ready", in_ready, !TRAP);
            step();
        end

        in_valid = 1'b0; rst = 1'b1;
        step(); rst = 1'b0; in_valid = 1'b1; inst_i = ADDI; pc_i = 32'h130; out_ready = 1'b1;
        step(); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); chk("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", out_valid, 0); chk("async_rst_imm", imm, 0);
        rst = 1'b0;

        cur = rand_inst();
        for (int c = 0; c < 3000; c++) begin
            step();
            if (m_acc) cur = rand_inst();
            rst = (c % 250 == 249);
            in_valid = ($urandom_range(0, 3) != 0);
            inst_i = cur;
            pc_i = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
        end
        step(); rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
